// File: rtl/ram_stream_tx_if.sv
// Bundle between ram_stream_tx and its neighbours: the synchronous-read RAM
// port on one side and the AXI-stream toward the sorter on the other.
interface ram_stream_tx_if #(
  parameter int WIDTH   = 16,
  parameter int ADDRESS = 4
);
  logic               en1;
  logic [ADDRESS-1:0] addr1;
  logic [WIDTH-1:0]   r_data1;
  logic               tvalid;
  logic               tready;
  logic [WIDTH-1:0]   tdata;
  logic               tlast;

  modport master (
    output en1, addr1, tvalid, tdata, tlast,
    input  r_data1, tready
  );

  modport slave (
    input  en1, addr1, tvalid, tdata, tlast,
    output r_data1, tready
  );
endinterface

// File: rtl/ram_stream_tx.sv
// Streams RAM words 0..len-1 out on AXI-stream through a 2-entry FIFO that
// hides the one-cycle RAM read latency while sustaining one word per cycle.
module ram_stream_tx #(
  parameter int WIDTH   = 16,
  parameter int ADDRESS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDRESS:0]   length,
  output logic               busy,
  output logic               done,
  ram_stream_tx_if.master    bus
);

  localparam int RAM_DEPTH = 2 ** ADDRESS;
  localparam logic [ADDRESS:0] DEPTH_LEN = (ADDRESS + 1)'(RAM_DEPTH);
  localparam logic [ADDRESS:0] LEN_ONE   = (ADDRESS + 1)'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [ADDRESS:0]   len_r;
  logic [ADDRESS:0]   rd_ptr_r;
  logic [ADDRESS:0]   len_sat_s;
  logic [ADDRESS-1:0] addr_r;
  logic               inflight_r;
  logic               inflight_last_r;
  logic               busy_r;
  logic               done_r;
  logic [1:0]         count_r;
  logic [WIDTH-1:0]   head_data_r;
  logic [WIDTH-1:0]   tail_data_r;
  logic               head_last_r;
  logic               tail_last_r;
  logic               pop_s;
  logic               push_s;
  logic               issue_s;
  logic               accept_s;
  logic [2:0]         occ_s;

  assign pop_s     = (count_r != 2'd0) && bus.tready;
  assign push_s    = inflight_r;
  // Occupancy the FIFO will have once this cycle's pop and pending push settle.
  assign occ_s     = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign len_sat_s = (length > DEPTH_LEN) ? DEPTH_LEN : length;

  assign bus.en1    = issue_s;
  assign bus.addr1  = issue_s ? rd_ptr_r[ADDRESS-1:0] : addr_r;
  assign bus.tvalid = (count_r != 2'd0);
  assign bus.tdata  = head_data_r;
  assign bus.tlast  = head_last_r;
  assign busy       = busy_r;
  assign done       = done_r;

  // Next-state and read-issue decision.
  always_comb begin
    state_s  = state_r;
    issue_s  = 1'b0;
    accept_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start && (length != '0)) begin
          state_s  = RUN;
          accept_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        issue_s = (rd_ptr_r < len_r) && (occ_s < 3'd2);
        if (pop_s && head_last_r) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, read pointer and in-flight read tracking.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r         <= IDLE;
      busy_r          <= 1'b0;
      done_r          <= 1'b0;
      len_r           <= '0;
      rd_ptr_r        <= '0;
      addr_r          <= '0;
      inflight_r      <= 1'b0;
      inflight_last_r <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy_r     <= (state_s == RUN);
      done_r     <= (state_s == DONE);
      inflight_r <= issue_s;
      if (accept_s) begin
        len_r    <= len_sat_s;
        rd_ptr_r <= '0;
      end else if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + LEN_ONE;
      end
      if (issue_s) begin
        addr_r          <= rd_ptr_r[ADDRESS-1:0];
        inflight_last_r <= (rd_ptr_r == (len_r - LEN_ONE));
      end
    end
  end

  // Two-entry FIFO; the head register drives the stream directly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r     <= 2'd0;
      head_data_r <= '0;
      tail_data_r <= '0;
      head_last_r <= 1'b0;
      tail_last_r <= 1'b0;
    end else begin
      case ({push_s, pop_s})
        2'b10: begin
          count_r <= count_r + 2'd1;
          if (count_r == 2'd0) begin
            head_data_r <= bus.r_data1;
            head_last_r <= inflight_last_r;
          end else begin
            tail_data_r <= bus.r_data1;
            tail_last_r <= inflight_last_r;
          end
        end
        2'b01: begin
          count_r <= count_r - 2'd1;
          if (count_r == 2'd2) begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
          end else begin
            // Emptied: drop the stale tag so tlast never shows without tvalid.
            head_last_r <= 1'b0;
          end
        end
        2'b11: begin
          if (count_r == 2'd1) begin
            head_data_r <= bus.r_data1;
            head_last_r <= inflight_last_r;
          end else begin
            head_data_r <= tail_data_r;
            head_last_r <= tail_last_r;
            tail_data_r <= bus.r_data1;
            tail_last_r <= inflight_last_r;
          end
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_stream_tx.sv
// Self-checking bench for ram_stream_tx: a RAM model, a word-queue reference
// and a per-cycle monitor, driven by directed and randomized transfers.
module tb_ram_stream_tx;
  localparam int WIDTH   = 16;
  localparam int ADDRESS = 4;
  localparam int DEPTH   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [ADDRESS:0] length = '0;
  logic             busy;
  logic             done;

  ram_stream_tx_if #(.WIDTH(WIDTH), .ADDRESS(ADDRESS)) bus ();

  ram_stream_tx #(.WIDTH(WIDTH), .ADDRESS(ADDRESS)) dut (
    .clk(clk), .reset(reset), .start(start), .length(length),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Synchronous-read RAM model
  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clk) if (bus.en1) bus.r_data1 <= ram[bus.addr1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // tready pattern generator
  int tr_mode = 0;
  int phase = 0;
  initial begin
    bus.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        0:       bus.tready = 1'b1;
        1:       bus.tready = ((phase % 3) == 0);
        2:       bus.tready = 1'($urandom_range(0, 1));
        default: bus.tready = 1'b0;
      endcase
      phase++;
    end
  end

  // Reference: expected {last, data} words of the current transfer
  logic [WIDTH:0] exp_q[$];
  int exp_len = 0;
  int start_cyc = 0;
  bit timing_mode = 1'b0;

  int issued = 0, popped = 0, xfer_issue = 0, done_cnt = 0;
  int first_cyc = 0, tlast_cyc = 0, done_cyc = 0, en1_first = 0, en1_last = 0, en1_cnt = 0;
  logic [WIDTH-1:0] first_word = '0, last_word = '0;
  bit stall = 1'b0;
  logic [WIDTH:0] stall_val = '0;

  always @(negedge clk) begin
    int widx;
    if (!reset) begin
      issued = 0; popped = 0; xfer_issue = 0; stall = 1'b0;
    end else begin
      check("occupancy_le2", 32'((issued - popped) <= 2), 32'd1);
      if (stall) begin
        check("stall_tvalid", bus.tvalid, 1'b1);
        check("stall_hold", {bus.tlast, bus.tdata}, stall_val);
      end
      if (bus.tvalid) begin
        check("word_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          widx = exp_len - exp_q.size();
          check("tdata", bus.tdata, exp_q[0][WIDTH-1:0]);
          check("tlast", bus.tlast, exp_q[0][WIDTH]);
          if (widx == 0) begin first_cyc = cyc; first_word = bus.tdata; end
          if (bus.tlast) begin tlast_cyc = cyc; last_word = bus.tdata; end
          if (timing_mode) check("word_cycle", cyc - start_cyc, 3 + widx);
          if (bus.tready) begin
            void'(exp_q.pop_front());
            popped++;
          end
        end
      end else begin
        check("tlast_without_tvalid", bus.tlast, 1'b0);
      end
      stall = bus.tvalid && !bus.tready;
      stall_val = {bus.tlast, bus.tdata};
      if (bus.en1) begin
        check("en1_busy", busy, 1'b1);
        check("addr1_order", bus.addr1, xfer_issue);
        if (en1_cnt == 0) en1_first = cyc;
        en1_last = cyc;
        en1_cnt++;
        xfer_issue++;
        issued++;
      end
      if (!busy) xfer_issue = 0;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        check("done_not_busy", busy, 1'b0);
        check("done_drained", exp_q.size(), 0);
      end
      if (!busy && !done && !bus.tvalid) en1_cnt = 0;
    end
  end

  // Caller sits just after a rising edge; start is high for the next cycle only.
  task automatic start_xfer(input int len_in);
    int l;
    l = (len_in > DEPTH) ? DEPTH : len_in;
    for (int i = 0; i < l; i++) exp_q.push_back({(i == l - 1), ram[i]});
    exp_len = l;
    #1;
    length = len_in[ADDRESS:0];
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input bit extra);
    int d0;
    bit ok;
    d0 = done_cnt;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      if (extra) begin
        #1;
        start = ((cyc - start_cyc) == 2) || ((cyc - start_cyc) == 5);
        length = 5'd8;
      end
    end
    start = 1'b0;
    check("done_seen", ok, 1'b1);
  endtask

  task automatic end_checks(input int l, input bit timed);
    check("words_left", exp_q.size(), 0);
    if (timed) begin
      check("first_latency", first_cyc - start_cyc, 3);
      check("tlast_cycle", tlast_cyc - start_cyc, l + 2);
      check("done_cycle", done_cyc - start_cyc, l + 3);
      check("en1_first", en1_first - start_cyc, 1);
      check("en1_last", en1_last - start_cyc, l);
      check("en1_count", en1_cnt, l);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_en1"}, bus.en1, 1'b0);
    check({tag, "_addr1"}, bus.addr1, 4'h0);
    check({tag, "_tvalid"}, bus.tvalid, 1'b0);
    check({tag, "_tdata"}, bus.tdata, 16'h0000);
    check({tag, "_tlast"}, bus.tlast, 1'b0);
  endtask

  initial begin
    int d0;
    int l;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk);

    // Ramp RAM, length 4, full throughput, plus literal pins of the model
    for (int i = 0; i < DEPTH; i++) ram[i] = 16'(16'h0010 * (i + 1));
    tr_mode = 0;
    timing_mode = 1'b1;
    start_xfer(4);
    wait_done(1'b0);
    end_checks(4, 1'b1);
    check("t4_first_word", first_word, 16'h0010);
    check("t4_last_word", last_word, 16'h0040);
    check("t4_tlast_cycle", tlast_cyc - start_cyc, 6);
    check("t4_done_cycle", done_cyc - start_cyc, 7);
    check("t4_en1_cycles", en1_cnt, 4);

    // Length 1, started in the first IDLE cycle
    start_xfer(1);
    wait_done(1'b0);
    end_checks(1, 1'b1);
    check("t1_word", first_word, 16'h0010);
    check("t1_tlast_cycle", tlast_cyc - start_cyc, 3);
    check("t1_done_cycle", done_cyc - start_cyc, 4);

    // Length 16 with tready toggling
    tr_mode = 1;
    timing_mode = 1'b0;
    start_xfer(16);
    wait_done(1'b0);
    end_checks(16, 1'b0);
    check("t16_last_word", last_word, 16'h0100);

    // Length 0 is ignored
    tr_mode = 0;
    #1;
    length = '0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("len0_busy", busy, 1'b0);
      check("len0_en1", bus.en1, 1'b0);
    end
    @(posedge clk);

    // Length 31 saturates to 16
    timing_mode = 1'b1;
    start_xfer(31);
    wait_done(1'b0);
    end_checks(16, 1'b1);

    // Extra start pulses in cycles 2 and 5 are ignored
    start_xfer(8);
    wait_done(1'b1);
    end_checks(8, 1'b1);
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    check("single_done", done_cnt, d0);

    // Reset in cycle 5 of a stalled length-8 transfer
    tr_mode = 3;
    timing_mode = 1'b0;
    start_xfer(8);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    tr_mode = 0;
    repeat (10) @(posedge clk);
    check("no_done_after_reset", done_cnt, d0);
    timing_mode = 1'b1;
    start_xfer(8);
    wait_done(1'b0);
    end_checks(8, 1'b1);
    check("restart_first_word", first_word, 16'h0010);

    // Randomized contents, lengths and backpressure
    timing_mode = 1'b0;
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < DEPTH; i++) ram[i] = 16'($urandom);
      l = $urandom_range(1, 31);
      tr_mode = (n % 3 == 0) ? 0 : 2;
      start_xfer(l);
      wait_done(1'b0);
      end_checks((l > DEPTH) ? DEPTH : l, 1'b0);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_stream_tx.md
# ram_stream_tx

Transmitter end of the sort datapath's input AXI-stream. On a start pulse it reads `length` consecutive words from a synchronous-read RAM port, starting at address 0, and emits them in address order on `tvalid`/`tready`/`tdata`/`tlast` toward the sorter. The last word is marked with `tlast`. Backpressure is honoured, and full throughput (one word per cycle) is sustained while `tready` stays high.

## Interface
- `WIDTH`, 16, data word width
- `ADDRESS`, 4, RAM address width; `RAM_DEPTH = 2**ADDRESS`

Ports:
- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a transfer; sampled only in IDLE
- `length`  in  ADDRESS+1  number of words to send; 0 means no transfer; values above RAM_DEPTH saturate to RAM_DEPTH
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle pulse after the final handshake
- `en1`  out  1  RAM read enable
- `addr1`  out  ADDRESS  RAM read address
- `r_data1`  in  WIDTH  RAM read data, valid the cycle after `en1`
- `tvalid`  out  1  stream word valid
- `tready`  in  1  downstream ready
- `tdata`  out  WIDTH  stream word
- `tlast`  out  1  marks the final word of the transfer

## Operation
- Reset (`reset`=0, async): state IDLE; FIFO empty; read pointer, length and in-flight flag cleared. All outputs are 0: `busy`, `done`, `en1`, `addr1`, `tvalid`, `tdata`, `tlast`.
- States:
  - IDLE → RUN on `start`=1 with `length`≠0. The block latches the saturated length as `len` and clears `rd_ptr`.
  - `start` with `length`=0 is ignored.
  - `start` is ignored in RUN and in DONE.
  - RUN → DONE on the handshake (`tvalid`&&`tready`) of word index `len`-1.
  - DONE → IDLE unconditionally after 1 cycle.
- Buffering: a 2-entry FIFO sits between the RAM and the stream. `tdata`/`tlast` are driven from the FIFO head register. `tvalid` = FIFO not empty.
- Read issue in RUN:
  - `en1`=1, `addr1`=`rd_ptr` when `rd_ptr` < `len` and (`count` + `inflight` − `pop`) < 2.
  - `count` = FIFO occupancy, `inflight` = read issued last cycle, `pop` = `tvalid`&&`tready`.
  - `rd_ptr` increments on each issue.
- Write side: `r_data1` is pushed into the FIFO in the cycle after an issue, tagged `last` when its address = `len`-1.
- FIFO never overflows and never underflows. Simultaneous push and pop keeps `count` unchanged.
- `addr1` holds its last value while `en1`=0.
- AXI-stream rules:
  - Once `tvalid`=1, `tvalid`, `tdata` and `tlast` stay stable until `tready`=1.
  - `tready` while `tvalid`=0 has no effect.
  - `tlast`=1 only on word `len`-1.
- `busy`=1 in RUN, 0 in IDLE and DONE. `done`=1 only in DONE.
- Reset mid-transfer: immediate return to IDLE with all outputs 0. No `done`. Pending and in-flight words are discarded.

## Timing
- Cycle 0: `start` sampled high in IDLE.
- Cycle 1: `busy`=1, `en1`=1, `addr1`=0.
- Cycle 2: `r_data1`=ram[0], captured at the end of the cycle.
- Cycle 3: `tvalid`=1, `tdata`=ram[0]. Start-to-first-word latency is 3 cycles.
- With `tready`=1 throughout:
  - Word i appears in cycle 3+i.
  - `tlast` is in cycle `len`+2.
  - `done` is in cycle `len`+3, and `busy`=0 there.
  - Total transfer: `len`+3 cycles; `en1` high for `len` consecutive cycles.
- Backpressure: with `tready`=0, at most 2 words are buffered. `en1` stops within 1 cycle once `count`+`inflight` = 2.
- When `tready` rises again, a pop occurs that same cycle. Output then resumes one word per cycle with no bubble, provided the reads are issued.
- A new `start` is accepted from cycle `len`+4, i.e. the first IDLE cycle.
- `len`=1: `tvalid` and `tlast` both rise in cycle 3.

## Test plan
- RAM = {0x0010, 0x0020, …}, `length`=4, `tready`=1 → `tdata` 0x0010, 0x0020, 0x0030, 0x0040 in cycles 3–6; `tlast` only in cycle 6; `done` in cycle 7; `en1` high only in cycles 1–4.
- `length`=16, `tready` toggling 1,0,0,1,… → 16 words in address order, none dropped or duplicated; `tdata`/`tlast` stable while stalled; `count` never exceeds 2.
- `length`=1 → a single word with `tlast`=1 in cycle 3; `done` in cycle 4.
- `length`=0, then `length`=31 with ADDRESS=4 → the first `start` is ignored (`busy` stays 0); the second sends 16 words (addresses 0–15).
- `start` pulsed again in cycles 2 and 5 of a `length`=8 transfer → ignored; exactly 8 words and one `done`.
- Reset asserted in cycle 5 of a `length`=8 transfer with `tready`=0 → every output is 0 in the same cycle; no `done`; a fresh `start` afterwards restarts from address 0 with a 3-cycle latency.
